// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner
// Greenhouse sensor front end. It synchronizes and debounces the raw PMOD sensor
// lines into a clean committed vector, and reports every committed change through
// a valid/ready event port.
//
// Ports
//   clk         master clock
//   rst         asynchronous active-low reset
//   sensor_raw  raw asynchronous sensor lines, bit order {M, L, T, H, S2, S1}
//   sensors     debounced committed sensor levels
//   evt_valid   an unreported change is pending
//   evt_mask    bits committed since the last accepted event
//   evt_ready   consumer accepts the pending event
//   glitch_cnt  saturating count of cycles with a rejected transition
//
// Optional feature macro: SENSOR_GLITCH_COUNT_EN enables the glitch counter.
// Without the macro, glitch_cnt is tied to zero.
module sensor_input_conditioner #(
    parameter int unsigned N_SENSORS       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor_raw,
    output logic [N_SENSORS-1:0] sensors,
    output logic                 evt_valid,
    output logic [N_SENSORS-1:0] evt_mask,
    input  logic                 evt_ready,
    output logic [7:0]           glitch_cnt
);

    localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [N_SENSORS-1:0] r_sync_a;
    logic [N_SENSORS-1:0] r_sync_b;
    logic [N_SENSORS-1:0] r_sync;
    logic [N_SENSORS-1:0] r_sensors;
    logic [CNT_W-1:0]     r_cnt     [N_SENSORS];
    logic [CNT_W-1:0]     w_cnt_nxt [N_SENSORS];
    logic [N_SENSORS-1:0] w_sensors_nxt;
    logic [N_SENSORS-1:0] w_commit;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_SENSORS-1:0] r_mask;
    logic [N_SENSORS-1:0] w_mask_nxt;

    // Input pipeline: sync is valid after the third sampling edge, so a raw edge
    // first sampled on edge 0 reaches the debounce compare after edge 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_sync   <= '0;
        end else begin
            r_sync_a <= sensor_raw;
            r_sync_b <= r_sync_a;
            r_sync   <= r_sync_b;
        end
    end

    // Per-bit debounce: count cycles of disagreement, commit on the last one.
    always_comb begin
        w_sensors_nxt = r_sensors;
        w_commit      = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync[i] != r_sensors[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_sensors_nxt[i] = r_sync[i];
                    w_commit[i]      = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sensors <= '0;
            for (int i = 0; i < int'(N_SENSORS); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sensors <= w_sensors_nxt;
            for (int i = 0; i < int'(N_SENSORS); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Event port state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Event port next state: commits accumulate while the consumer stalls, and an
    // accept that coincides with a commit reloads the mask with only the new bits.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        case (r_state)
            ST_IDLE: begin
                if (|w_commit) begin
                    w_state_nxt = ST_PENDING;
                    w_mask_nxt  = w_commit;
                end
            end
            ST_PENDING: begin
                if (!evt_ready) begin
                    w_mask_nxt = r_mask | w_commit;
                end else if (|w_commit) begin
                    w_mask_nxt = w_commit;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_mask_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mask_nxt  = '0;
            end
        endcase
    end

    assign sensors   = r_sensors;
    assign evt_valid = (r_state == ST_PENDING);
    assign evt_mask  = r_mask;

`ifdef SENSOR_GLITCH_COUNT_EN
    logic [7:0] r_glitch_cnt;
    logic       w_glitch_any;

    // A glitch is a counter dropping back to zero from nonzero without a commit.
    always_comb begin
        w_glitch_any = 1'b0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if ((r_sync[i] == r_sensors[i]) && (r_cnt[i] != '0)) begin
                w_glitch_any = 1'b1;
            end
        end
    end

    // One increment per cycle regardless of how many bits glitched; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch_any && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_sensor_input_conditioner;

    localparam int unsigned N = 6;
    localparam int unsigned D = 4;

`ifdef SENSOR_GLITCH_COUNT_EN
    localparam logic [7:0] EXP_GLITCH_ONE = 8'd1;
    localparam logic [7:0] EXP_GLITCH_SAT = 8'd255;
`else
    localparam logic [7:0] EXP_GLITCH_ONE = 8'd0;
    localparam logic [7:0] EXP_GLITCH_SAT = 8'd0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] sensor_raw;
    logic [N-1:0] sensors;
    logic         evt_valid;
    logic [N-1:0] evt_mask;
    logic         evt_ready;
    logic [7:0]   glitch_cnt;

    int n_checks;
    int n_errors;

    sensor_input_conditioner #(
        .N_SENSORS       (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .sensors    (sensors),
        .evt_valid  (evt_valid),
        .evt_mask   (evt_mask),
        .evt_ready  (evt_ready),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; drive and sample 1 time unit after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    logic valid_dropped;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        sensor_raw = '0;
        evt_ready  = 1'b0;
        #1;
        tick(3);

        // Reset state
        check("rst_sensors", 32'(sensors), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_mask", 32'(evt_mask), 32'd0);
        check("rst_glitch", 32'(glitch_cnt), 32'd0);
        rst = 1'b1;
        tick(2);

        // Basic rise: first sampling edge is edge 0, commit lands on edge 6
        sensor_raw = 6'b000001;
        tick(6);
        check("rise_early_sensors", 32'(sensors), 32'd0);
        check("rise_early_valid", 32'(evt_valid), 32'd0);
        tick(1);
        check("rise_sensors", 32'(sensors), 32'b000001);
        check("rise_valid", 32'(evt_valid), 32'd1);
        check("rise_mask", 32'(evt_mask), 32'b000001);
        evt_ready = 1'b1;
        tick(1);
        check("rise_ack_valid", 32'(evt_valid), 32'd0);
        check("rise_ack_mask", 32'(evt_mask), 32'd0);

        // Glitch: bit 3 high for 3 synchronized cycles only
        sensor_raw = 6'b001001;
        tick(3);
        sensor_raw = 6'b000001;
        tick(10);
        check("glitch_sensors", 32'(sensors), 32'b000001);
        check("glitch_valid", 32'(evt_valid), 32'd0);
        check("glitch_cnt_one", 32'(glitch_cnt), 32'(EXP_GLITCH_ONE));

        // Back-pressure: bit0 rise, bit5 rise, bit0 fall, all held pending
        evt_ready  = 1'b0;
        sensor_raw = 6'b000000;
        do_reset();
        sensor_raw = 6'b000001;
        tick(7);
        check("bp_first_valid", 32'(evt_valid), 32'd1);
        valid_dropped = 1'b0;
        sensor_raw = 6'b100001;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (!evt_valid) valid_dropped = 1'b1;
        end
        check("bp_mid_mask", 32'(evt_mask), 32'b100001);
        sensor_raw = 6'b100000;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            if (!evt_valid) valid_dropped = 1'b1;
        end
        check("bp_mask", 32'(evt_mask), 32'b100001);
        check("bp_sensors", 32'(sensors), 32'b100000);
        check("bp_valid_held", 32'(valid_dropped), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("bp_ack_valid", 32'(evt_valid), 32'd0);
        check("bp_ack_mask", 32'(evt_mask), 32'd0);

        // Simultaneous accept and commit: bit1 pending, bit2 commits one edge later
        sensor_raw = 6'b100010;
        tick(1);
        sensor_raw = 6'b100110;
        tick(6);
        check("sim_pend_valid", 32'(evt_valid), 32'd1);
        check("sim_pend_mask", 32'(evt_mask), 32'b000010);
        evt_ready = 1'b1;
        tick(1);
        check("sim_valid", 32'(evt_valid), 32'd1);
        check("sim_mask", 32'(evt_mask), 32'b000100);
        check("sim_sensors", 32'(sensors), 32'b100110);
        tick(1);
        check("sim_drain_valid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Reset mid-debounce: bit 4 two counts in, then async reset
        sensor_raw = 6'b110110;
        tick(5);
        rst = 1'b0;
        #1;
        check("mid_rst_sensors", 32'(sensors), 32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_mask", 32'(evt_mask), 32'd0);
        check("mid_rst_glitch", 32'(glitch_cnt), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(6);
        check("mid_rel_early", 32'(sensors), 32'd0);
        tick(1);
        check("mid_rel_sensors", 32'(sensors), 32'b110110);
        check("mid_rel_mask", 32'(evt_mask), 32'b110110);

        // Saturation: 300 one-cycle glitches on bit 3
        evt_ready = 1'b1;
        for (int g = 0; g < 300; g++) begin
            sensor_raw = 6'b111110;
            tick(1);
            sensor_raw = 6'b110110;
            tick(1);
        end
        tick(5);
        check("sat_glitch", 32'(glitch_cnt), 32'(EXP_GLITCH_SAT));
        check("sat_sensors", 32'(sensors), 32'b110110);
        check("sat_valid", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
